// File: rtl/spi_master_param.sv
`timescale 1ns/1ps
// Parametrised full-duplex SPI master with CPOL/CPHA modes, bit ordering and multiple chip selects.
// One clock domain; every SPI pin and handshake output comes straight from a flop.
module spi_master_param #(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned CS_NUM   = 1,
  parameter  int unsigned DIV_W    = 8,
  localparam int unsigned CS_SEL_W = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIV_W-1:0]    sclk_divider,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                lsb_first,
  input  logic [CS_SEL_W-1:0] cs_sel,
  input  logic                start,
  input  logic [DATA_W-1:0]   tx_data,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   rx_data,
  input  logic                SPI_miso,
  output logic                SPI_mosi,
  output logic                SPI_sclk,
  output logic [CS_NUM-1:0]   SPI_csn
);

  localparam int unsigned EDGES  = 2 * DATA_W;
  localparam int unsigned EDGE_W = $clog2(EDGES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_TRANSFER,
    S_CS_HOLD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_first_q, lsb_first_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mosi_q, mosi_d;
  logic              sclk_q, sclk_d;
  logic [CS_NUM-1:0] csn_q, csn_d;

  logic              period_end_c;
  logic              edge_now_c;
  logic              sample_edge_c;
  logic              last_edge_c;
  logic [DATA_W-1:0] tx_ordered_c;
  logic [CS_NUM-1:0] cs_decode_c;

  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      r[i] = v[DATA_W-1-i];
    end
    return r;
  endfunction

  // Both shift registers always move MSB-first; LSB-first is handled by reversing at the ends.
  assign tx_ordered_c  = lsb_first ? bit_reverse(tx_data) : tx_data;
  assign period_end_c  = (div_cnt_q == div_q);
  // edge_cnt_q counts completed edges, so an even count means the next edge is a leading one
  assign sample_edge_c = edge_cnt_q[0] ^ ~cpha_q;
  assign last_edge_c   = (edge_cnt_q == EDGE_W'(EDGES - 1));
  assign edge_now_c    = period_end_c &&
                         ((state_q == S_CS_SETUP) ||
                          ((state_q == S_TRANSFER) && (edge_cnt_q != EDGE_W'(EDGES))));

  // Out-of-range selects leave every chip select deasserted.
  always_comb begin
    cs_decode_c = '1;
    for (int unsigned i = 0; i < CS_NUM; i++) begin
      if (cs_sel == CS_SEL_W'(i)) begin
        cs_decode_c[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    edge_cnt_d  = edge_cnt_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsb_first_d = lsb_first_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mosi_d      = mosi_q;
    sclk_d      = sclk_q;
    csn_d       = csn_q;
    div_cnt_d   = period_end_c ? '0 : div_cnt_q + DIV_W'(1);

    unique case (state_q)
      S_IDLE: begin
        div_cnt_d = '0;
        sclk_d    = cpol;
        mosi_d    = 1'b0;
        csn_d     = '1;
        if (start) begin
          state_d     = S_CS_SETUP;
          busy_d      = 1'b1;
          div_d       = sclk_divider;
          cpol_d      = cpol;
          cpha_d      = cpha;
          lsb_first_d = lsb_first;
          edge_cnt_d  = '0;
          rx_sr_d     = '0;
          csn_d       = cs_decode_c;
          if (cpha) begin
            tx_sr_d = tx_ordered_c;
          end else begin
            mosi_d  = tx_ordered_c[DATA_W-1];
            tx_sr_d = {tx_ordered_c[DATA_W-2:0], 1'b0};
          end
        end
      end
      S_CS_SETUP: begin
        if (period_end_c) begin
          state_d = S_TRANSFER;
        end
      end
      S_TRANSFER: begin
        if (period_end_c && (edge_cnt_q == EDGE_W'(EDGES))) begin
          state_d = S_CS_HOLD;
        end
      end
      S_CS_HOLD: begin
        sclk_d = cpol_q;
        if (period_end_c) begin
          state_d   = S_DONE;
          csn_d     = '1;
          done_d    = 1'b1;
          rx_data_d = lsb_first_q ? bit_reverse(rx_sr_q) : rx_sr_q;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        mosi_d    = 1'b0;
        div_cnt_d = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // SCLK edge: sample MISO on the sample edge, otherwise present the next TX bit.
    if (edge_now_c) begin
      sclk_d     = ~sclk_q;
      edge_cnt_d = edge_cnt_q + EDGE_W'(1);
      if (sample_edge_c) begin
        rx_sr_d = {rx_sr_q[DATA_W-2:0], SPI_miso};
      end else if (!last_edge_c) begin
        mosi_d  = tx_sr_q[DATA_W-1];
        tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      div_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_first_q <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mosi_q      <= 1'b0;
      sclk_q      <= 1'b0;
      csn_q       <= '1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      div_cnt_q   <= div_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsb_first_q <= lsb_first_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mosi_q      <= mosi_d;
      sclk_q      <= sclk_d;
      csn_q       <= csn_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_data_q;
  assign SPI_mosi = mosi_q;
  assign SPI_sclk = sclk_q;
  assign SPI_csn  = csn_q;

endmodule

// File: tb/tb_spi_master_param.sv
`timescale 1ns/1ps
// Bench for spi_master_param: protocol-level SPI slave model, rx_data scoreboard and timing checks.
module tb_spi_master_param;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned CS_NUM   = 3;
  localparam int unsigned DIV_W    = 8;
  localparam int unsigned CS_SEL_W = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [DIV_W-1:0]    sclk_divider;
  logic                cpol, cpha, lsb_first;
  logic [CS_SEL_W-1:0] cs_sel;
  logic                start;
  logic [DATA_W-1:0]   tx_data;
  logic                busy, done;
  logic [DATA_W-1:0]   rx_data;
  logic                spi_miso, spi_mosi, spi_sclk;
  logic [CS_NUM-1:0]   spi_csn;

  logic                loopback = 1'b1;
  logic                m_cpha   = 1'b0;
  logic                m_lsb    = 1'b0;
  logic [DATA_W-1:0]   slave_word = '0;
  logic                slv_miso = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [DATA_W-1:0] exp_q[$];

  assign spi_miso = loopback ? spi_mosi : slv_miso;

  spi_master_param #(
    .DATA_W(DATA_W),
    .CS_NUM(CS_NUM),
    .DIV_W (DIV_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk_divider(sclk_divider),
    .cpol        (cpol),
    .cpha        (cpha),
    .lsb_first   (lsb_first),
    .cs_sel      (cs_sel),
    .start       (start),
    .tx_data     (tx_data),
    .busy        (busy),
    .done        (done),
    .rx_data     (rx_data),
    .SPI_miso    (spi_miso),
    .SPI_mosi    (spi_mosi),
    .SPI_sclk    (spi_sclk),
    .SPI_csn     (spi_csn)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [DATA_W-1:0] rev8(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  function automatic logic [CS_NUM-1:0] exp_csn(input logic [CS_SEL_W-1:0] sel);
    logic [CS_NUM-1:0] e;
    e = '1;
    if (int'(sel) < CS_NUM) e[sel] = 1'b0;
    return e;
  endfunction

  function automatic int bit_pos(input int n);
    return m_lsb ? n : DATA_W - 1 - n;
  endfunction

  // Slave model: reacts to SCLK edges seen at the falling clk edge.
  logic              slv_act_prev = 1'b0;
  logic              sclk_prev    = 1'b0;
  int                slv_edges = 0, slv_txn = 0, slv_rxn = 0;
  int                last_edge_cyc = 0, gap_min = 0, gap_max = 0;
  logic [DATA_W-1:0] slv_rx = '0, mosi_seq = '0;

  initial forever begin
    logic act;
    int   gap;
    @(negedge clk);
    act = (spi_csn != '1);
    if (act && !slv_act_prev) begin
      slv_edges = 0; slv_txn = 0; slv_rxn = 0;
      gap_min = 1 << 30; gap_max = 0;
      slv_rx = '0; mosi_seq = '0;
      if (!m_cpha) begin
        slv_miso = slave_word[bit_pos(0)];
        slv_txn  = 1;
      end
    end else if (act && (spi_sclk != sclk_prev)) begin
      slv_edges++;
      if (slv_edges > 1) begin
        gap = cyc - last_edge_cyc;
        if (gap < gap_min) gap_min = gap;
        if (gap > gap_max) gap_max = gap;
      end
      last_edge_cyc = cyc;
      if (((slv_edges % 2) == 1) == !m_cpha) begin
        if (slv_rxn < DATA_W) begin
          slv_rx[bit_pos(slv_rxn)] = spi_mosi;
          mosi_seq = {mosi_seq[DATA_W-2:0], spi_mosi};
          slv_rxn++;
        end
      end else if (slv_txn < DATA_W) begin
        slv_miso = slave_word[bit_pos(slv_txn)];
        slv_txn++;
      end
    end
    slv_act_prev = act;
    sclk_prev    = spi_sclk;
  end

  // Scoreboard: every done pops one expected word.
  initial forever begin
    @(negedge clk);
    if (done === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_done", 32'd1, 32'd0);
      else check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
  end

  // Called at a falling edge with the master idle.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] sw, input logic pol, input logic pha,
                      input logic lsb, input logic [1:0] sel, input logic [7:0] div,
                      input logic lb, input bit disturb, input bit b2b);
    int                n;
    logic [CS_NUM-1:0] csn_acc;
    m_cpha = pha; m_lsb = lsb; slave_word = sw; loopback = lb;
    cpol = pol; cpha = pha; lsb_first = lsb; cs_sel = sel; sclk_divider = div; tx_data = tx;
    if (!b2b) begin
      @(negedge clk);
      check("sclk_idle_pre", 32'(spi_sclk), 32'(pol));
    end
    check("busy_pre", 32'(busy), 32'd0);
    exp_q.push_back(lb ? tx : sw);
    start = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    check("busy_accept", 32'(busy), 32'd1);
    check("csn_first", 32'(spi_csn), 32'(exp_csn(sel)));
    csn_acc = spi_csn;
    while ((done !== 1'b1) && (n < 1000)) begin
      start = disturb && (n == 5);
      if (disturb && (n == 5)) begin
        tx_data = ~tx; cpol = ~pol; lsb_first = ~lsb;
        cs_sel = sel + 2'd1; sclk_divider = div + 8'd3;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      csn_acc = csn_acc & spi_csn;
    end
    start = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    check("done_latency", 32'(n), 32'((2 * DATA_W + 2) * (int'(div) + 1) + 1));
    check("busy_at_done", 32'(busy), 32'd1);
    check("sclk_idle_post", 32'(spi_sclk), 32'(pol));
    check("csn_pattern", 32'(csn_acc), 32'(exp_csn(sel)));
    if (int'(sel) < CS_NUM) begin
      check("slave_rx", 32'(slv_rx), 32'(tx));
      check("mosi_seq", 32'(mosi_seq), 32'(lsb ? rev8(tx) : tx));
      check("sclk_edges", 32'(slv_edges), 32'(2 * DATA_W));
      check("sclk_gap_min", 32'(gap_min), 32'(int'(div) + 1));
      check("sclk_gap_max", 32'(gap_max), 32'(int'(div) + 1));
    end
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("csn_after", 32'(spi_csn), 32'(3'b111));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    cs_sel = '0; sclk_divider = '0; tx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_csn", 32'(spi_csn), 32'(3'b111));
    rst_n = 1'b1;
    @(negedge clk);

    //    tx     slave  pol   pha   lsb   sel   div   lb    dist b2b
    xfer(8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, 1'b1, 0, 0);
    xfer(8'hC3, 8'h3C, 1'b1, 1'b1, 1'b0, 2'd1, 8'd2, 1'b0, 0, 0);
    xfer(8'h0D, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'd0, 1'b1, 0, 0);
    xfer(8'h5A, 8'h96, 1'b0, 1'b1, 1'b0, 2'd2, 8'd3, 1'b0, 0, 0);
    xfer(8'h27, 8'hE1, 1'b1, 1'b0, 1'b1, 2'd1, 8'd1, 1'b0, 0, 0);
    xfer(8'h6B, 8'h00, 1'b0, 1'b0, 1'b0, 2'd3, 8'd1, 1'b1, 0, 0);
    xfer(8'h9E, 8'h4D, 1'b0, 1'b0, 1'b0, 2'd2, 8'd1, 1'b0, 1, 0);
    xfer(8'h31, 8'hB7, 1'b0, 1'b0, 1'b0, 2'd2, 8'd1, 1'b0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      xfer(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom_range(0, 2)), 8'($urandom_range(0, 3)), 1'b0, 0, 0);
    end

    // Reset in the middle of a mode-2 transfer.
    m_cpha = 1'b0; m_lsb = 1'b0; loopback = 1'b1;
    cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; cs_sel = 2'd0; sclk_divider = 8'd1; tx_data = 8'h77;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_csn", 32'(spi_csn), 32'(3'b111));
    check("abort_sclk", 32'(spi_sclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rx_data", 32'(rx_data), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
    xfer(8'hE4, 8'h1F, 1'b0, 1'b1, 1'b0, 2'd1, 8'd1, 1'b0, 0, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised full-duplex SPI master, the next generation of the team's 8-bit write-only SPI transmitter. It adds configurable word width, all four CPOL/CPHA modes, MSB- or LSB-first ordering, MISO capture and multiple chip selects. It sits between a register/command front end (start/done handshake) and the external SPI pins, with one clock domain throughout.

## Interface
- DATA_W, 8: bits per transfer, 2..32
- CS_NUM, 1: number of chip-select lines, 1..8
- DIV_W, 8: width of sclk_divider
- CS_SEL_W, derived: $clog2(CS_NUM), minimum 1

Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sclk_divider  in  DIV_W  SCLK half-period minus one, in clk cycles (H = sclk_divider+1)
- cpol  in  1  SCLK idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- lsb_first  in  1  1: LSB shifted first
- cs_sel  in  CS_SEL_W  chip-select index for the transfer
- start  in  1  transfer request; accepted only when busy=0
- tx_data  in  DATA_W  word to transmit
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- rx_data  out  DATA_W  last received word, held until next done
- SPI_miso  in  1  serial input
- SPI_mosi  out  1  serial output
- SPI_sclk  out  1  serial clock
- SPI_csn  out  CS_NUM  active-low chip selects

## Operation
- FSM states: IDLE -> CS_SETUP -> TRANSFER -> CS_HOLD -> DONE -> IDLE.
- IDLE:
  - start=1 latches tx_data, sclk_divider, cpol, cpha, lsb_first and cs_sel, then goes to CS_SETUP.
  - SPI_sclk follows cpol registered, with one cycle of lag.
  - SPI_mosi=0; all SPI_csn high.
- CS_SETUP: lasts H cycles. SPI_csn[cs_sel] is low and SPI_sclk holds at the latched cpol. For cpha=0 the first data bit is on SPI_mosi from the first CS_SETUP cycle.
- TRANSFER: 2*DATA_W SCLK edges, one every H cycles; the first edge occurs at the end of CS_SETUP.
  - Odd-numbered edges are leading; even-numbered edges are trailing.
  - Sample edge: leading if cpha=0, trailing if cpha=1. At each sample edge SPI_miso shifts into the RX shift register.
  - Shift edge: the opposite edge. At each shift edge the next TX bit is driven.
  - cpha=1: the first bit is driven at edge 1; the final trailing edge drives no new bit.
  - Bit order: MSB-first (tx_data[DATA_W-1] first) when lsb_first=0, otherwise LSB-first. rx_data is assembled with the same ordering, so a loopback returns tx_data unchanged.
  - After edge 2*DATA_W, SPI_sclk equals cpol.
- CS_HOLD: lasts H cycles with SCLK idle and the selected CSn still low. It exits with all CSn high.
- DONE: one cycle. done=1 and rx_data is updated in this cycle; busy is still 1. Next state is IDLE.
- cs_sel >= CS_NUM: the transfer runs normally but no CSn is asserted.
- start during busy is ignored and has no side effect.
- Changes to the configuration inputs during busy have no effect until the next accepted start.

## Timing
- Reset values (asynchronous, immediate):
  - busy=0, done=0, rx_data=0, SPI_mosi=0, SPI_sclk=0, SPI_csn all 1.
  - FSM returns to IDLE and the divider counter clears.
  - Reset mid-transfer aborts the transfer with no done pulse.
- start sampled high at clk edge k:
  - busy=1 from cycle k+1.
  - CSn falls in cycle k+1.
  - done=1 in cycle k+1+(2*DATA_W+2)*H.
  - busy=0 the cycle after done.
- A new start is accepted in the first cycle busy=0, so back-to-back period is (2*DATA_W+2)*H+2 cycles.
- SPI_sclk and SPI_mosi are registered outputs, glitch-free. MISO is sampled on the same clk edge that makes the SCLK sample transition.
- sclk_divider=0 (H=1): SCLK = clk/2, which must still work.
- Maximum divider is 2^DIV_W-1. The divider counter wraps only at the latched value.

## Test plan
- DATA_W=8, mode 0, divider=1, MISO looped to MOSI, tx 0xA5 → rx_data=0xA5, done exactly 37 cycles after start, MOSI bit sequence 1,0,1,0,0,1,0,1.
- Mode 3 (cpol=1, cpha=1), slave model returning 0x3C, tx 0xC3 → slave captures 0xC3, rx_data=0x3C, SCLK idles high before and after.
- lsb_first=1, DATA_W=16, tx 0x8001, loopback → first MOSI bit 1, rx_data=0x8001; divider=0 gives SCLK = clk/2.
- CS_NUM=4, cs_sel=2 → only SPI_csn[2] low (pattern 4'b1011) during the transfer; cs_sel=3 with CS_NUM=3 → no CSn asserted, done still pulses.
- start pulsed again 5 cycles into a transfer, and tx_data/cpol changed mid-transfer → ignored, and the original word is sent unchanged. A start in the cycle after done → accepted.
- rst_n asserted midway through a transfer → CSn all high and SCLK=0 immediately, no done pulse. A fresh transfer after release completes normally.
